knn_dist_engine: RTL and testbench

- Parametrised, pipelined distance engine for the KNN accelerator.
- Accepts one query point plus a K-entry candidate list (knn_entry_t) per request, then computes a distance for every candidate.
- Streams results LANES entries per beat to the downstream sorter/merger over a valid/ready handshake with full backpressure.
- Successor to the single-entry combinational distance stage. Adds a selectable metric (true squared-L2 or L1), lane parallelism, invalid-entry handling and flow control.

---
 rtl/knn_dist_engine.sv | 201 ++++++++++++++++++++
 tb/tb_knn_dist_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_dist_engine.sv
// Two-stage pipelined squared-L2 / L1 distance engine emitting LANES candidates per beat.
// Entry packing, MSB..LSB: {valid, point_id[ID_WIDTH], x, y, z, distance[DIST_WIDTH]}.
module knn_dist_engine #(
  parameter int BIT_WIDTH  = 16,
  parameter int K          = 8,
  parameter int LANES      = 2,
  parameter int ID_WIDTH   = 16,
  parameter int DIST_WIDTH = 2*BIT_WIDTH + 4,
  localparam int NBEATS    = (K + LANES - 1) / LANES,
  localparam int BIW       = $clog2(NBEATS) + 1,
  localparam int EW        = 1 + ID_WIDTH + 3*BIT_WIDTH + DIST_WIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_mode,
  input  logic [BIT_WIDTH-1:0] i_qp_x,
  input  logic [BIT_WIDTH-1:0] i_qp_y,
  input  logic [BIT_WIDTH-1:0] i_qp_z,
  input  logic [K*EW-1:0]      i_cand_in,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [LANES*EW-1:0]  o_out_entry,
  output logic [LANES-1:0]     o_out_lane_valid,
  output logic [BIW-1:0]       o_out_beat_idx,
  output logic                 o_out_last,
  output logic                 o_busy
);

  localparam int PW = EW - DIST_WIDTH;
  localparam int OZ = 0;
  localparam int OY = BIT_WIDTH;
  localparam int OX = 2*BIT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [BIW-1:0]         r_issue_ptr;
  logic [K*PW-1:0]        r_hold_cand;
  logic [K*PW-1:0]        w_cand_pass;
  logic [K-1:0]           w_unused_dist;
  logic [BIT_WIDTH-1:0]   r_hold_qx, r_hold_qy, r_hold_qz;
  logic                   r_hold_mode;
  logic                   r_s1_valid, r_s1_last, r_s1_mode;
  logic [BIW-1:0]         r_s1_beat;
  logic                   r_out_valid, r_out_last;
  logic [BIW-1:0]         r_out_beat;
  logic [PW-1:0]          w_slot [NBEATS*LANES];
  logic                   w_advance, w_accept, w_issue, w_feed_last;

  function automatic logic [BIT_WIDTH:0] abs_diff(input logic [BIT_WIDTH-1:0] c,
                                                 input logic [BIT_WIDTH-1:0] q);
    logic [BIT_WIDTH:0] d;
    d = {c[BIT_WIDTH-1], c} - {q[BIT_WIDTH-1], q};
    return d[BIT_WIDTH] ? -d : d;
  endfunction

  assign w_advance   = !r_out_valid || i_out_ready;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_issue     = (r_state == S_ISSUE) && w_advance;
  assign w_feed_last = (r_issue_ptr == BIW'(NBEATS - 1));

  assign o_req_ready    = (r_state == S_IDLE) && !i_reset;
  assign o_busy         = (r_state != S_IDLE);
  assign o_out_valid    = r_out_valid;
  assign o_out_last     = r_out_last;
  assign o_out_beat_idx = r_out_beat;

  // The incoming distance field is meaningless and is not held.
  for (genvar gi = 0; gi < K; gi++) begin : g_cand
    assign w_cand_pass[gi*PW +: PW] = i_cand_in[gi*EW + DIST_WIDTH +: PW];
    assign w_unused_dist[gi]        = ^i_cand_in[gi*EW +: DIST_WIDTH];
  end

  // Slots past K are hard zero so the final beat's padding lanes need no special case.
  for (genvar gi = 0; gi < NBEATS*LANES; gi++) begin : g_slot
    if (gi < K) begin : g_real
      assign w_slot[gi] = r_hold_cand[gi*PW +: PW];
    end else begin : g_pad
      assign w_slot[gi] = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_issue_ptr <= '0;
      r_hold_cand <= '0;
      r_hold_qx   <= '0;
      r_hold_qy   <= '0;
      r_hold_qz   <= '0;
      r_hold_mode <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_issue_ptr <= '0;
        r_hold_cand <= w_cand_pass;
        r_hold_qx   <= i_qp_x;
        r_hold_qy   <= i_qp_y;
        r_hold_qz   <= i_qp_z;
        r_hold_mode <= i_req_mode;
      end else if (w_issue) begin
        r_issue_ptr <= r_issue_ptr + BIW'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
      S_ISSUE: if (w_issue && w_feed_last) w_state_next = S_DRAIN;
      S_DRAIN: if (r_out_valid && i_out_ready && r_out_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_beat   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_beat  <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= w_issue;
      r_s1_last   <= w_issue && w_feed_last;
      r_s1_mode   <= r_hold_mode;
      r_s1_beat   <= w_issue ? r_issue_ptr : '0;
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_last;
      r_out_beat  <= r_s1_beat;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PW-1:0]         w_feed;
    logic                  w_feed_lv;
    logic [PW-1:0]         r_s1_pass;
    logic [BIT_WIDTH:0]    r_s1_ax, r_s1_ay, r_s1_az;
    logic                  r_s1_lv;
    logic [DIST_WIDTH-1:0] w_l2, w_l1, w_dist;
    logic [EW-1:0]         r_out_entry;
    logic                  r_out_lv;

    always_comb begin
      w_feed    = '0;
      w_feed_lv = 1'b0;
      for (int b = 0; b < NBEATS; b++) begin
        if (r_issue_ptr == BIW'(b)) begin
          w_feed    = w_slot[b*LANES + gi];
          w_feed_lv = (b*LANES + gi) < K;
        end
      end
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_s1_pass <= '0;
        r_s1_ax   <= '0;
        r_s1_ay   <= '0;
        r_s1_az   <= '0;
        r_s1_lv   <= 1'b0;
      end else if (w_advance) begin
        r_s1_pass <= w_issue ? w_feed : '0;
        r_s1_ax   <= w_issue ? abs_diff(w_feed[OX +: BIT_WIDTH], r_hold_qx) : '0;
        r_s1_ay   <= w_issue ? abs_diff(w_feed[OY +: BIT_WIDTH], r_hold_qy) : '0;
        r_s1_az   <= w_issue ? abs_diff(w_feed[OZ +: BIT_WIDTH], r_hold_qz) : '0;
        r_s1_lv   <= w_issue && w_feed_lv;
      end
    end

    // Invalid candidates report the maximum distance so the sorter ranks them last.
    always_comb begin
      w_l2 = DIST_WIDTH'(r_s1_ax) * DIST_WIDTH'(r_s1_ax)
           + DIST_WIDTH'(r_s1_ay) * DIST_WIDTH'(r_s1_ay)
           + DIST_WIDTH'(r_s1_az) * DIST_WIDTH'(r_s1_az);
      w_l1 = DIST_WIDTH'(r_s1_ax) + DIST_WIDTH'(r_s1_ay) + DIST_WIDTH'(r_s1_az);
      if (!r_s1_pass[PW-1]) w_dist = '1;
      else                  w_dist = r_s1_mode ? w_l1 : w_l2;
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_out_entry <= '0;
        r_out_lv    <= 1'b0;
      end else if (w_advance) begin
        r_out_entry <= r_s1_lv ? {r_s1_pass, w_dist} : '0;
        r_out_lv    <= r_s1_lv;
      end
    end

    assign o_out_entry[gi*EW +: EW] = r_out_entry;
    assign o_out_lane_valid[gi]     = r_out_lv;
  end

endmodule

// File: tb/tb_knn_dist_engine.sv
// Directed, table-driven bench for knn_dist_engine (BIT_WIDTH=16, K=5, LANES=2).
module tb_knn_dist_engine;

  localparam int BW  = 16;
  localparam int K   = 5;
  localparam int L   = 2;
  localparam int ID  = 16;
  localparam int DW  = 36;
  localparam int NB  = 3;
  localparam int BIW = 3;
  localparam int EW  = 1 + ID + 3*BW + DW;

  typedef struct packed {
    logic                 mode;
    logic [BW-1:0]        qx, qy, qz;
    logic [K-1:0][BW-1:0] cx, cy, cz;
    logic [K-1:0]         cv;
    logic [K-1:0][DW-1:0] ed;
  } vec_t;

  logic            clk = 1'b0;
  logic            i_reset, i_req_valid, i_req_mode, i_out_ready;
  logic [BW-1:0]   i_qp_x, i_qp_y, i_qp_z;
  logic [K*EW-1:0] i_cand_in;
  logic            o_req_ready, o_out_valid, o_out_last, o_busy;
  logic [L*EW-1:0] o_out_entry;
  logic [L-1:0]    o_out_lane_valid;
  logic [BIW-1:0]  o_out_beat_idx;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_errors = 0;

  knn_dist_engine #(.BIT_WIDTH(BW), .K(K), .LANES(L), .ID_WIDTH(ID), .DIST_WIDTH(DW)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_mode(i_req_mode), .i_qp_x(i_qp_x), .i_qp_y(i_qp_y), .i_qp_z(i_qp_z),
    .i_cand_in(i_cand_in), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_entry(o_out_entry), .o_out_lane_valid(o_out_lane_valid),
    .o_out_beat_idx(o_out_beat_idx), .o_out_last(o_out_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setq(input int v, input logic mode, input logic [BW-1:0] x, y, z);
    vecs[v].mode = mode;
    vecs[v].qx = x;
    vecs[v].qy = y;
    vecs[v].qz = z;
  endtask

  task automatic setc(input int v, input int i, input logic [BW-1:0] x, y, z,
                      input logic val, input logic [DW-1:0] d);
    vecs[v].cx[i] = x;
    vecs[v].cy[i] = y;
    vecs[v].cz[i] = z;
    vecs[v].cv[i] = val;
    vecs[v].ed[i] = d;
  endtask

  function automatic logic [EW-1:0] exp_entry(input int v, input int i);
    if (i >= K) return '0;
    return {vecs[v].cv[i], 16'(v*16 + i + 1), vecs[v].cx[i], vecs[v].cy[i], vecs[v].cz[i],
            vecs[v].ed[i]};
  endfunction

  task automatic start_req(input int v);
    i_req_mode = vecs[v].mode;
    i_qp_x = vecs[v].qx;
    i_qp_y = vecs[v].qy;
    i_qp_z = vecs[v].qz;
    for (int i = 0; i < K; i++)
      i_cand_in[i*EW +: EW] = {vecs[v].cv[i], 16'(v*16 + i + 1), vecs[v].cx[i],
                               vecs[v].cy[i], vecs[v].cz[i], 36'hA5A5A5A5A};
    i_req_valid = 1'b1;
    chk($sformatf("v%0d_req_ready_idle", v), o_req_ready, 1);
    @(posedge clk); #1;
    // Scramble everything after acceptance: the engine must use its captured copy.
    i_req_valid = 1'b0;
    i_req_mode  = ~vecs[v].mode;
    for (int w = 0; w < K*EW; w++) i_cand_in[w] = 1'($urandom);
    i_qp_x = 16'($urandom);
    i_qp_y = 16'($urandom);
    i_qp_z = 16'($urandom);
    chk($sformatf("v%0d_busy", v), o_busy, 1);
    chk($sformatf("v%0d_req_ready_busy", v), o_req_ready, 0);
  endtask

  task automatic check_beat(input int v, input int b);
    logic [L-1:0] elv;
    chk($sformatf("v%0d_b%0d_out_valid", v, b), o_out_valid, 1);
    chk($sformatf("v%0d_b%0d_beat_idx", v, b), o_out_beat_idx, b);
    chk($sformatf("v%0d_b%0d_out_last", v, b), o_out_last, (b == NB-1));
    for (int l = 0; l < L; l++) elv[l] = (b*L + l < K);
    chk($sformatf("v%0d_b%0d_lane_valid", v, b), o_out_lane_valid, elv);
    for (int l = 0; l < L; l++)
      chk($sformatf("v%0d_b%0d_l%0d_entry", v, b, l), o_out_entry[l*EW +: EW],
          exp_entry(v, b*L + l));
  endtask

  task automatic run_req(input int v, input int stall_beat, input int stall_n);
    int cyc;
    int b;
    int expc;
    start_req(v);
    cyc = 1;
    b = 0;
    while (b < NB && cyc < 40) begin
      if (o_out_valid) begin
        expc = 3 + b + ((stall_beat >= 0 && b > stall_beat) ? stall_n : 0);
        chk($sformatf("v%0d_b%0d_latency", v, b), cyc, expc);
        check_beat(v, b);
        if (b == stall_beat) begin
          i_out_ready = 1'b0;
          repeat (stall_n) begin
            @(posedge clk); #1;
            cyc++;
            check_beat(v, b);
            chk($sformatf("v%0d_req_ready_stall", v), o_req_ready, 0);
          end
          i_out_ready = 1'b1;
        end
        $display("vec %0d beat %0d cycle %0d lanes %b dist0 %0d", v, b, cyc,
                 o_out_lane_valid, o_out_entry[DW-1:0]);
        b++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d_beats_received", v), b, NB);
    chk($sformatf("v%0d_out_valid_after", v), o_out_valid, 0);
    chk($sformatf("v%0d_busy_after", v), o_busy, 0);
    chk($sformatf("v%0d_req_ready_after", v), o_req_ready, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_out_last"}, o_out_last, 0);
    chk({tag, "_beat_idx"}, o_out_beat_idx, 0);
    chk({tag, "_lane_valid"}, o_out_lane_valid, 0);
    chk({tag, "_entry"}, o_out_entry, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_req_ready_in_reset"}, o_req_ready, 0);
  endtask

  initial begin
    // Basic L2 / L1, extremes in both metrics, invalid candidate.
    setq(0, 1'b0, 0, 0, 0);
    setc(0, 0, 3, 4, 0, 1'b1, 25);
    setc(0, 1, 1, 1, 1, 1'b1, 3);
    setc(0, 2, 16'hFFFE, 0, 0, 1'b1, 4);
    setc(0, 3, 0, 0, 16'hFFFB, 1'b1, 25);
    setc(0, 4, 7, 0, 0, 1'b1, 49);
    vecs[1] = vecs[0];
    vecs[1].mode = 1'b1;
    vecs[1].ed[0] = 7; vecs[1].ed[1] = 3; vecs[1].ed[2] = 2; vecs[1].ed[3] = 5; vecs[1].ed[4] = 7;
    setq(2, 1'b0, 16'h8000, 16'h8000, 16'h8000);
    setc(2, 0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 36'd12884508675);
    setc(2, 1, 16'h8000, 16'h8000, 16'h8000, 1'b1, 36'd0);
    setc(2, 2, 0, 0, 0, 1'b1, 36'd3221225472);
    setc(2, 3, 16'h7FFF, 16'h8000, 16'h8000, 1'b1, 36'd4294836225);
    setc(2, 4, 1, 1, 1, 1'b0, 36'hFFFFFFFFF);
    vecs[3] = vecs[2];
    vecs[3].mode = 1'b1;
    vecs[3].ed[0] = 36'd196605; vecs[3].ed[1] = 36'd0; vecs[3].ed[2] = 36'd98304;
    vecs[3].ed[3] = 36'd65535;  vecs[3].ed[4] = 36'hFFFFFFFFF;
    vecs[4] = vecs[0];
    vecs[4].cv[1] = 1'b0;
    vecs[4].ed[1] = 36'hFFFFFFFFF;

    i_reset = 1'b1;
    i_req_valid = 1'b0;
    i_req_mode = 1'b0;
    i_out_ready = 1'b1;
    i_qp_x = '0;
    i_qp_y = '0;
    i_qp_z = '0;
    i_cand_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    i_reset = 1'b0;
    #1;
    chk("req_ready_after_reset", o_req_ready, 1);

    for (int v = 0; v < 5; v++) run_req(v, -1, 0);

    // Backpressure: stall beat 1 of the basic request for 4 cycles.
    run_req(0, 1, 4);

    // Reset while beat 1 is on the output.
    start_req(2);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_beat1_present", o_out_beat_idx, 1);
    i_reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    i_reset = 1'b0;
    #1;
    chk("midreset_req_ready_after", o_req_ready, 1);
    run_req(1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
